// File: rtl/fb_pkg.sv
// Shared types and default frame geometry for the frame-buffer load controller.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } state_t;

endpackage

// File: rtl/fb_xy_counter.sv
// Raster x/y position counter; load_origin places the counter just past pixel (0,0).
module fb_xy_counter
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDRW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic             load_origin,
  output logic [ADDRW-1:0] x,
  output logic [ADDRW-1:0] y,
  output logic             last
);

  localparam logic [ADDRW-1:0] X_MAX = ADDRW'(WIDTH - 1);
  localparam logic [ADDRW-1:0] Y_MAX = ADDRW'(HEIGHT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (load_origin) begin
      x <= ADDRW'(1);
      y <= '0;
    end else if (step) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/fb_load_ctrl.sv
// Frame-buffer load controller: rasterises loader beats into write-port cycles.
// Define FB_LOAD_CTRL_DOUBLE_BUF_EN for double buffering with vsync-timed bank swaps.
module fb_load_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDRW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_data,
  input  logic             pix_sof,
  input  logic             vsync,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_wx,
  output logic [ADDRW-1:0] mem_wy,
  output logic             mem_wdata,
  output logic             mem_wbank,
  output logic             mem_rbank,
  output logic             frame_done,
  output logic             sync_err,
  output logic [15:0]      frames_shown
);

  state_t           state;
  logic             hs;
  logic             wr;
  logic             fin;
  logic             err;
  logic             cnt_clear;
  logic             cnt_step;
  logic             cnt_origin;
  logic             cnt_last;
  logic [ADDRW-1:0] cnt_x;
  logic [ADDRW-1:0] cnt_y;

  fb_xy_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDRW (ADDRW)
  ) u_xy (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .step       (cnt_step),
    .load_origin(cnt_origin),
    .x          (cnt_x),
    .y          (cnt_y),
    .last       (cnt_last)
  );

  assign pix_ready = (state != S_FULL);
  assign hs        = pix_valid & pix_ready;

  // A start-of-frame beat always lands at (0,0), whether it opens or restarts a frame.
  always_comb begin
    wr         = 1'b0;
    fin        = 1'b0;
    err        = 1'b0;
    cnt_clear  = 1'b0;
    cnt_step   = 1'b0;
    cnt_origin = 1'b0;
    if (hs) begin
      if (pix_sof) begin
        wr         = 1'b1;
        cnt_origin = 1'b1;
        err        = (state == S_FILL);
      end else if (state == S_FILL) begin
        wr = 1'b1;
        if (cnt_last) begin
          fin       = 1'b1;
          cnt_clear = 1'b1;
        end else begin
          cnt_step = 1'b1;
        end
      end else begin
        err = 1'b1;
      end
    end
  end

`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
  assign mem_wbank = ~mem_rbank;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign mem_rbank    = 1'b0;
  assign mem_wbank    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_wx       <= '0;
      mem_wy       <= '0;
      mem_wdata    <= 1'b0;
      frame_done   <= 1'b0;
      sync_err     <= 1'b0;
      frames_shown <= '0;
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
      mem_rbank    <= 1'b0;
`endif
    end else begin
      mem_we     <= wr;
      frame_done <= fin;
      if (wr) begin
        mem_wx    <= pix_sof ? '0 : cnt_x;
        mem_wy    <= pix_sof ? '0 : cnt_y;
        mem_wdata <= pix_data;
      end
      if (err) sync_err <= 1'b1;
      case (state)
        S_IDLE: if (hs && pix_sof) state <= S_FILL;
        S_FILL: begin
          if (fin) begin
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
            state <= S_FULL;
`else
            state        <= S_IDLE;
            frames_shown <= frames_shown + 16'd1;
`endif
          end
        end
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
        // vsync during the final handshake sees FILL here, so the swap waits for the next one.
        S_FULL: begin
          if (vsync) begin
            state        <= S_IDLE;
            mem_rbank    <= ~mem_rbank;
            frames_shown <= frames_shown + 16'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_load_ctrl.sv
// Scoreboard bench for fb_load_ctrl at WIDTH=4, HEIGHT=3; follows FB_LOAD_CTRL_DOUBLE_BUF_EN if defined.
module tb_fb_load_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic          pix_sof;
  logic          vsync;
  logic          mem_we;
  logic [AW-1:0] mem_wx;
  logic [AW-1:0] mem_wy;
  logic          mem_wdata;
  logic          mem_wbank;
  logic          mem_rbank;
  logic          frame_done;
  logic          sync_err;
  logic [15:0]   frames_shown;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic          d;
    logic          done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  fb_load_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDRW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .vsync       (vsync),
    .mem_we      (mem_we),
    .mem_wx      (mem_wx),
    .mem_wy      (mem_wy),
    .mem_wdata   (mem_wdata),
    .mem_wbank   (mem_wbank),
    .mem_rbank   (mem_rbank),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .frames_shown(frames_shown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write-port cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got write at (%0d,%0d) expected none", mem_wx, mem_wy);
        end else begin
          mon_e = q.pop_front();
          check("wx", 32'(mem_wx), 32'(mon_e.x));
          check("wy", 32'(mem_wy), 32'(mon_e.y));
          check("wdata", 32'(mem_wdata), 32'(mon_e.d));
          check("frame_done", 32'(frame_done), 32'(mon_e.done));
        end
      end else if (frame_done) begin
        check("frame_done_without_we", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic beat(input logic d, input logic sof, input bit push, input int idx,
                      input bit done, input logic vs);
    @(negedge clk);
    check("pix_ready_at_beat", 32'(pix_ready), 32'd1);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    vsync     = vs;
    if (push) q.push_back('{x: AW'(idx % W), y: AW'(idx / W), d: d, done: done});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      vsync     = 1'b0;
    end
  endtask

  task automatic send_frame(input logic vs_last);
    for (int i = 0; i < W * H; i++)
      beat(((i % 2) == 0), (i == 0), 1'b1, i, (i == W * H - 1), (i == W * H - 1) ? vs_last : 1'b0);
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_wx"}, 32'(mem_wx), 32'd0);
    check({tag, "_wy"}, 32'(mem_wy), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rbank"}, 32'(mem_rbank), 32'd0);
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
    check({tag, "_wbank"}, 32'(mem_wbank), 32'd1);
`else
    check({tag, "_wbank"}, 32'(mem_wbank), 32'd0);
`endif
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    check({tag, "_frames_shown"}, 32'(frames_shown), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = 1'b0;
    pix_sof   = 1'b0;
    vsync     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(pix_ready), 32'd1);

    // First frame, data 1010..., frame_done on write 12
    send_frame(1'b0);
    idle(2);
    check("sync_err_clean", 32'(sync_err), 32'd0);
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
    check("ready_full", 32'(pix_ready), 32'd0);
    check("fs_before_swap", 32'(frames_shown), 32'd0);
    check("rbank_before_swap", 32'(mem_rbank), 32'd0);
    pulse_vsync();
    check("rbank_swap1", 32'(mem_rbank), 32'd1);
    check("wbank_swap1", 32'(mem_wbank), 32'd0);
    check("fs_swap1", 32'(frames_shown), 32'd1);
    check("ready_after_swap", 32'(pix_ready), 32'd1);
    pulse_vsync();
    check("rbank_vsync_idle", 32'(mem_rbank), 32'd1);
    check("fs_vsync_idle", 32'(frames_shown), 32'd1);
`else
    check("ready_single", 32'(pix_ready), 32'd1);
    check("fs_frame1", 32'(frames_shown), 32'd1);
    pulse_vsync();
    check("rbank_single", 32'(mem_rbank), 32'd0);
    check("wbank_single", 32'(mem_wbank), 32'd0);
    check("fs_vsync_ignored", 32'(frames_shown), 32'd1);
`endif

    // Partial frame of 5 beats, then a restarting sof beat and the rest of the frame
    for (int i = 0; i < 5; i++) beat(((i % 2) == 0), (i == 0), 1'b1, i, 1'b0, 1'b0);
    send_frame(1'b0);
    idle(2);
    check("sync_err_restart", 32'(sync_err), 32'd1);
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
    check("ready_full2", 32'(pix_ready), 32'd0);
    pulse_vsync();
    check("rbank_swap2", 32'(mem_rbank), 32'd0);
    check("fs_swap2", 32'(frames_shown), 32'd2);
    // vsync coincident with the final handshake must not swap
    send_frame(1'b1);
    idle(2);
    check("rbank_no_swap", 32'(mem_rbank), 32'd0);
    check("fs_no_swap", 32'(frames_shown), 32'd2);
    check("ready_no_swap", 32'(pix_ready), 32'd0);
    idle(8);
    pulse_vsync();
    check("rbank_late_swap", 32'(mem_rbank), 32'd1);
    check("wbank_late_swap", 32'(mem_wbank), 32'd0);
    check("fs_late_swap", 32'(frames_shown), 32'd3);
`else
    check("fs_frame2", 32'(frames_shown), 32'd2);
    // Two back-to-back frames with no idle cycle between them
    send_frame(1'b0);
    send_frame(1'b0);
    idle(2);
    check("fs_back_to_back", 32'(frames_shown), 32'd4);
    check("rbank_back_to_back", 32'(mem_rbank), 32'd0);
    check("wbank_back_to_back", 32'(mem_wbank), 32'd0);
`endif

    // Reset in the middle of a frame
    for (int i = 0; i < 7; i++) beat(((i % 2) == 0), (i == 0), 1'b1, i, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_midrst", 32'(pix_ready), 32'd1);
    beat(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    check("sync_err_no_sof", 32'(sync_err), 32'd1);
    check("we_after_discard", 32'(mem_we), 32'd0);
    send_frame(1'b0);
    idle(2);
`ifdef FB_LOAD_CTRL_DOUBLE_BUF_EN
    check("fs_after_midrst", 32'(frames_shown), 32'd0);
    check("ready_after_midrst_frame", 32'(pix_ready), 32'd0);
`else
    check("fs_after_midrst", 32'(frames_shown), 32'd1);
`endif
    check("sync_err_sticky", 32'(sync_err), 32'd1);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
